instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Program counter and instruction register stage directly upstream of the multicycle control unit.
//   Holds PC and IR, performs instruction reads over a req/ack memory handshake, and supplies opcode to control.
//   Applies PCWrite/PCWriteCond/PCSource decisions from control to update PC (PC+4, branch target, jump).
//   Raises fetch_busy so control holds in FETCH until the instruction is latched.
// PARAMETERS
//   RESET_PC        32'h0000_0000  PC value loaded on reset
//   TIMEOUT_CYCLES  8'd255         max wait cycles for mem_ack (used only with FETCH_TIMEOUT_EN)
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   reset          in   1   asynchronous, active-low reset
//   ir_write       in   1   IRWrite from control: start an instruction fetch at current PC
//   pc_write       in   1   unconditional PC update enable
//   pc_write_cond  in   1   conditional PC update enable (qualified by alu_zero)
//   pc_source      in   2   00 alu_result, 01 alu_out, 10 jump target, 11 hold
//   alu_result     in   32  combinational ALU result (PC+4 path)
//   alu_out        in   32  registered ALU output (branch target)
//   alu_zero       in   1   ALU zero flag
//   mem_req        out  1   instruction read request, held until acked
//   mem_addr       out  32  read address, PC captured at fetch start
//   mem_rdata      in   32  read data, valid in cycle mem_ack=1
//   mem_ack        in   1   read completion
//   pc             out  32  current program counter
//   instr          out  32  instruction register
//   op_code        out  6   instr[31:26]
//   fetch_busy     out  1   high in REQ state (control must stall)
//   fetch_done     out  1   one-cycle pulse in the cycle after instr is updated
//   fetch_err      out  1   sticky timeout flag (0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//   Reset (async, reset=0): pc=RESET_PC, instr=0, state=IDLE, mem_req=0, mem_addr=0, fetch_done=0, fetch_err=0, wait counter=0.
//   FSM IDLE -> REQ on ir_write; REQ -> DONE on mem_ack; DONE -> IDLE unconditionally.
//   REQ: mem_req=1, fetch_busy=1, mem_addr held at PC captured on IDLE->REQ edge.
//   On mem_ack in REQ: instr <= mem_rdata; DONE follows, fetch_done=1 for exactly that cycle.
//   Min latency: ir_write cycle t -> mem_req cycle t+1 -> ack t+1 -> instr and fetch_done valid t+2.
//   ir_write while in REQ or DONE ignored (no queueing). mem_ack outside REQ ignored.
//   PC update every cycle in any state: pc_en = pc_write | (pc_write_cond & alu_zero).
//   pc_en & pc_source=00 -> alu_result; 01 -> alu_out; 10 -> {pc[31:28], instr[25:0], 2'b00}; 11 -> pc unchanged.
//   PC update during REQ does not alter mem_addr of the in-flight fetch.
//   pc_write and pc_write_cond both high: pc_write wins (update regardless of alu_zero).
//   PC arithmetic is done by the ALU; no internal adder; no alignment checking; wrap-around is ALU's 32-bit wrap.
//   Reset mid-fetch: request dropped immediately (mem_req=0 asynchronously); late ack after reset ignored.
// CONFIGURATION
//   FETCH_TIMEOUT_EN defined: 8-bit wait counter clears on IDLE->REQ, increments each REQ cycle without ack;
//     when it reaches TIMEOUT_CYCLES with no ack: go to DONE, instr <= 32'h0 (NOP), fetch_done=1,
//     fetch_err set and held until reset. Ack in same cycle as limit wins (normal latch, no error).
//   FETCH_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, fetch_err tied to 0.
// TESTING
//   Reset release, RESET_PC=0x100 -> pc=0x100, instr=0, mem_req=0, fetch_err=0.
//   ir_write=1 at pc=0x100, ack 3 cycles later with rdata=0x2008_0005 -> mem_addr=0x100 held, op_code=6'b001000, one fetch_done pulse.
//   pc_write=1, pc_source=10, instr=0x0800_0040, pc=0x1000_0000 -> pc=0x1000_0100.
//   pc_write_cond=1, pc_source=01, alu_out=0x200: alu_zero=0 -> pc unchanged; alu_zero=1 -> pc=0x200.
//   pc_write=1, pc_source=00, alu_result=0x104 during REQ at 0x100 -> pc=0x104, mem_addr stays 0x100.
//   FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> after 4 REQ cycles instr=0, fetch_done pulse, fetch_err=1 sticky.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Program counter and instruction register stage that sits in front of a
//   multicycle control unit. It fetches one instruction per ir_write request
//   over a req/ack memory handshake, presents the opcode to control, and
//   applies the PCWrite / PCWriteCond / PCSource decisions from control.
//
//   Optional feature: define FETCH_TIMEOUT_EN to bound the wait for mem_ack.
//   On a timeout the IR is loaded with a NOP (32'h0), fetch_done still pulses,
//   and fetch_err is set and held until reset. Without the macro REQ waits
//   indefinitely and fetch_err is tied low.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   ir_write              start an instruction fetch at the current PC
//   pc_write              unconditional PC update enable
//   pc_write_cond         PC update enable qualified by alu_zero
//   pc_source[1:0]        00 alu_result, 01 alu_out, 10 jump target, 11 hold
//   alu_result, alu_out   PC+4 path / registered branch target from the ALU
//   alu_zero              ALU zero flag
//   mem_req, mem_addr     instruction read request and its address
//   mem_rdata, mem_ack    read data and completion strobe
//   pc, instr, op_code    current PC, instruction register, instr[31:26]
//   fetch_busy            high while a fetch is outstanding (control stalls)
//   fetch_done            one-cycle pulse once instr holds the new word
//   fetch_err             sticky timeout flag
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_write,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_mem_addr;
    logic        r_mem_req;
    logic        r_fetch_done;
    logic        w_pc_en;
    logic [31:0] w_pc_next;

    // pc_write dominates: when it is set, alu_zero does not matter.
    assign w_pc_en = pc_write | (pc_write_cond & alu_zero);

    always_comb begin
        w_pc_next = r_pc;
        case (pc_source)
            2'b00:   w_pc_next = alu_result;
            2'b01:   w_pc_next = alu_out;
            2'b10:   w_pc_next = {r_pc[31:28], r_instr[25:0], 2'b00};
            default: w_pc_next = r_pc;
        endcase
    end

    // PC is independent of the fetch FSM; updates during REQ leave the
    // in-flight mem_addr untouched since that was captured at fetch start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_fetch_err;
    logic [7:0] w_wait_nxt;

    assign w_wait_nxt = r_wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_instr      <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_req    <= 1'b0;
            r_fetch_done <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ir_write) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_wait_cnt <= 8'd0;
                    end
                end
                S_REQ: begin
                    // An ack arriving on the limit cycle still wins.
                    if (mem_ack) begin
                        r_instr      <= mem_rdata;
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_fetch_done <= 1'b1;
                    end else if (w_wait_nxt == TIMEOUT_CYCLES) begin
                        r_instr      <= 32'h0;
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_fetch_done <= 1'b1;
                        r_fetch_err  <= 1'b1;
                        r_wait_cnt   <= w_wait_nxt;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_err = r_fetch_err;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_instr      <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_req    <= 1'b0;
            r_fetch_done <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ir_write) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_instr      <= mem_rdata;
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_fetch_done <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The timeout limit only matters when the wait counter exists.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign fetch_err        = 1'b0;
`endif

    assign pc         = r_pc;
    assign instr      = r_instr;
    assign op_code    = r_instr[31:26];
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign fetch_busy = (r_state == S_REQ);
    assign fetch_done = r_fetch_done;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_write, pc_write, pc_write_cond, alu_zero, mem_ack;
    logic [1:0]  pc_source;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic        mem_req, fetch_busy, fetch_done, fetch_err;
    logic [31:0] mem_addr, pc, instr;
    logic [5:0]  op_code;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0100),
        .TIMEOUT_CYCLES (8'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .pc            (pc),
        .instr         (instr),
        .op_code       (op_code),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err)
    );

    // Stimulus helpers (no checking inside).
    task automatic do_fetch(input logic [31:0] rdata);
        ir_write = 1'b1;
        @(negedge clk);
        ir_write  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_write   = 1'b1;
        pc_source  = 2'b00;
        alu_result = v;
        @(negedge clk);
        pc_write = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; ir_write = 0; pc_write = 0; pc_write_cond = 0; alu_zero = 0;
        mem_ack = 0; pc_source = 2'b00; alu_result = 0; alu_out = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (pc !== 32'h100) $display("FAIL reset_pc got %h exp %h", pc, 32'h100); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL reset_mem got req=%b addr=%h exp 0/0", mem_req, mem_addr); else n_pass++;
        n_checks++; if (fetch_err !== 1'b0 || fetch_done !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL reset_flags got err=%b done=%b busy=%b exp 000", fetch_err, fetch_done, fetch_busy); else n_pass++;
    endtask

    task automatic test_fetch;
        ir_write  = 1'b1;
        mem_rdata = 32'h2008_0005;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== 32'h100) $display("FAIL fetch_start got req=%b busy=%b addr=%h exp 1/1/100", mem_req, fetch_busy, mem_addr); else n_pass++;
        // ir_write kept high while in REQ must be ignored.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || fetch_done !== 1'b0) $display("FAIL fetch_hold%0d got req=%b addr=%h done=%b exp 1/100/0", i, mem_req, mem_addr, fetch_done); else n_pass++;
        end
        ir_write = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clk);
        mem_ack  = 1'b0;
        n_checks++; if (instr !== 32'h2008_0005 || op_code !== 6'b001000) $display("FAIL fetch_instr got %h op=%b exp 20080005 op=001000", instr, op_code); else n_pass++;
        n_checks++; if (fetch_done !== 1'b1 || mem_req !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL fetch_done got done=%b req=%b busy=%b exp 1/0/0", fetch_done, mem_req, fetch_busy); else n_pass++;
        ir_write = 1'b1;   // arrives in DONE: must be dropped
        @(negedge clk);
        ir_write = 1'b0;
        n_checks++; if (fetch_done !== 1'b0 || mem_req !== 1'b0) $display("FAIL fetch_pulse_end got done=%b req=%b exp 0/0", fetch_done, mem_req); else n_pass++;
        mem_ack   = 1'b1;  // stray ack in IDLE
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (instr !== 32'h2008_0005 || fetch_done !== 1'b0 || mem_req !== 1'b0) $display("FAIL stray_ack got instr=%h done=%b req=%b exp 20080005/0/0", instr, fetch_done, mem_req); else n_pass++;
    endtask

    task automatic test_jump;
        do_fetch(32'h0800_0040);
        set_pc(32'h1000_0000);
        n_checks++; if (pc !== 32'h1000_0000) $display("FAIL jump_setup got %h exp 10000000", pc); else n_pass++;
        pc_write  = 1'b1;
        pc_source = 2'b10;
        @(negedge clk);
        pc_write = 1'b0;
        n_checks++; if (pc !== 32'h1000_0100) $display("FAIL jump_target got %h exp 10000100", pc); else n_pass++;
    endtask

    task automatic test_cond_branch;
        pc_write_cond = 1'b1; pc_source = 2'b01; alu_out = 32'h200; alu_zero = 1'b0;
        @(negedge clk);
        n_checks++; if (pc !== 32'h1000_0100) $display("FAIL cond_not_taken got %h exp 10000100", pc); else n_pass++;
        alu_zero = 1'b1;
        @(negedge clk);
        pc_write_cond = 1'b0;
        n_checks++; if (pc !== 32'h200) $display("FAIL cond_taken got %h exp 200", pc); else n_pass++;
        pc_write = 1'b1; pc_source = 2'b11; alu_result = 32'h999;
        @(negedge clk);
        n_checks++; if (pc !== 32'h200) $display("FAIL src_hold got %h exp 200", pc); else n_pass++;
        pc_write_cond = 1'b1; alu_zero = 1'b0; pc_source = 2'b00; alu_result = 32'h300;
        @(negedge clk);
        pc_write = 1'b0; pc_write_cond = 1'b0;
        n_checks++; if (pc !== 32'h300) $display("FAIL write_wins got %h exp 300", pc); else n_pass++;
    endtask

    task automatic test_pc_during_req;
        set_pc(32'h100);
        ir_write = 1'b1;
        @(negedge clk);
        ir_write = 1'b0;
        pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h104;
        @(negedge clk);
        pc_write = 1'b0;
        n_checks++; if (pc !== 32'h104 || mem_addr !== 32'h100 || mem_req !== 1'b1) $display("FAIL pc_in_req got pc=%h addr=%h req=%b exp 104/100/1", pc, mem_addr, mem_req); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (instr !== 32'h0000_1234 || fetch_done !== 1'b1) $display("FAIL req_ack got instr=%h done=%b exp 00001234/1", instr, fetch_done); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch;
        ir_write = 1'b1;
        @(negedge clk);
        ir_write = 1'b0;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL midrst_pre got req=%b exp 1", mem_req); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || pc !== 32'h100 || instr !== 32'h0 || mem_addr !== 32'h0) $display("FAIL midrst_async got req=%b pc=%h instr=%h addr=%h exp 0/100/0/0", mem_req, pc, instr, mem_addr); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (instr !== 32'h0 || fetch_done !== 1'b0 || mem_req !== 1'b0) $display("FAIL late_ack got instr=%h done=%b req=%b exp 0/0/0", instr, fetch_done, mem_req); else n_pass++;
    endtask

    task automatic test_timeout;
`ifdef FETCH_TIMEOUT_EN
        int req_cycles = 0;
        int guard = 0;
        ir_write = 1'b1;
        @(negedge clk);
        ir_write = 1'b0;
        while (fetch_done !== 1'b1 && guard < 20) begin
            if (mem_req === 1'b1) req_cycles++;
            guard++;
            @(negedge clk);
        end
        n_checks++; if (fetch_done !== 1'b1) $display("FAIL timeout_done got %b exp 1 (budget expired)", fetch_done); else n_pass++;
        n_checks++; if (req_cycles != 4) $display("FAIL timeout_len got %0d exp 4", req_cycles); else n_pass++;
        n_checks++; if (instr !== 32'h0 || fetch_err !== 1'b1) $display("FAIL timeout_nop got instr=%h err=%b exp 0/1", instr, fetch_err); else n_pass++;
        do_fetch(32'h1111_2222);
        n_checks++; if (fetch_err !== 1'b1 || instr !== 32'h1111_2222) $display("FAIL err_sticky got err=%b instr=%h exp 1/11112222", fetch_err, instr); else n_pass++;
`else
        ir_write = 1'b1;
        @(negedge clk);
        ir_write = 1'b0;
        repeat (300) @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || fetch_err !== 1'b0 || fetch_done !== 1'b0) $display("FAIL no_timeout got req=%b err=%b done=%b exp 1/0/0", mem_req, fetch_err, fetch_done); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (instr !== 32'h3333_4444 || fetch_done !== 1'b1) $display("FAIL long_wait_ack got instr=%h done=%b exp 33334444/1", instr, fetch_done); else n_pass++;
`endif
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_jump;
        test_cond_branch;
        test_pc_during_req;
        test_reset_mid_fetch;
        test_timeout;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
